instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the instruction decoder/controller: owns the PC, issues word reads to
//  instruction memory over a valid/ready request + in-order response channel, buffers returned
//  words with their PC in a small FIFO, and presents {instr, instr_pc} downstream with valid/ready.
//  Accepts a redirect (branch/jump target) that flushes all buffered and in-flight fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset (bits[1:0] must be 0)
//  FIFO_DEPTH  2              instr buffer entries = max outstanding imem requests (power of 2, >=2)
// PORTS
//  clk             in   1   single clock, all state on rising edge
//  rst             in   1   synchronous, active-high reset
//  imem_req_valid  out  1   request valid
//  imem_req_addr   out  32  byte address of word to fetch (bits[1:0]=0)
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_rsp_valid  in   1   response word valid (in request order, no backpressure)
//  imem_rsp_data   in   32  fetched instruction word
//  redirect_valid  in   1   replace PC, flush pipeline this cycle
//  redirect_pc     in   32  new PC (bits[1:0] forced to 0)
//  instr_valid     out  1   instr/instr_pc valid to decoder
//  instr           out  32  instruction word (FIFO head)
//  instr_pc        out  32  PC of instr
//  instr_ready     in   1   decoder consumes head this cycle
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc<=RESET_PC, FIFO empty, outstanding<=0, kill<=0; imem_req_valid=0,
//    instr_valid=0 in the cycle rst is high; first request issues the cycle after rst deasserts.
//  - Credits: imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH).
//    Guarantees every response has a FIFO slot; no response is ever dropped for lack of space.
//  - Request accept (valid&&ready): pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), outstanding+1,
//    accepted address pushed to an addr-tag queue (depth FIFO_DEPTH) for pairing with response.
//  - Response: outstanding-1, tag popped; if kill>0 then kill-1 and word discarded, else
//    {imem_rsp_data, tag} written to FIFO. Request accept + response same cycle: outstanding net 0.
//  - Output: instr_valid = FIFO non-empty; head popped on instr_valid&&instr_ready. Latency
//    minimum 1 cycle from rsp to instr_valid (FIFO registered, no bypass). Push+pop same cycle
//    when full allowed (count unchanged).
//  - Redirect (priority over everything except rst): pc<={redirect_pc[31:2],2'b00}; FIFO and tag
//    queue flushed; kill<=outstanding - (rsp arriving this cycle ? 1:0); no request issued this
//    cycle; instr_valid forced 0 this cycle; a same-cycle instr_ready pop is ignored.
//    First request to new PC the following cycle, limited by credits (kill counts as outstanding).
//  - rsp_valid with outstanding==0: protocol error; ignored (assertion in sim).
//  - Redirect mid-reset: rst wins. Back-to-back redirects: last one wins, kill accumulates correctly.
//  - Throughput: 1 instr/cycle sustained with zero-wait memory and instr_ready=1.
// STRUCTURE
//  - rv32_pkg: RESET_PC default, XLEN=32, INSTR_BYTES=4, NOP=32'h0000_0013 constant.
//  - Sub-module fetch_fifo (sync FIFO, params WIDTH, DEPTH; push/pop/flush, full/empty/count);
//    instantiated twice: instr buffer WIDTH=64 {pc,instr}, tag queue WIDTH=32.
//  - Top: PC reg, outstanding/kill counters ($clog2(FIFO_DEPTH)+1 bits), credit logic.
// TESTING
//  1 Reset: rst 3 cycles, zero-wait mem -> first req addr 0x0 cycle after rst low, then 0x4,0x8.
//  2 Streaming: mem returns mem[a]=a^0xA5A5_0000, instr_ready=1 -> instr_pc 0,4,8.. 1/cycle,
//    instr matches, no gaps after warm-up.
//  3 Backpressure: instr_ready=0 10 cycles -> exactly FIFO_DEPTH reqs issued, FIFO holds pc 0,4;
//    release -> 0,4,8 delivered in order, none lost/duplicated.
//  4 Redirect with 2 in flight (2-cycle mem latency): redirect_pc=0x103 -> both stale rsps
//    discarded, next instr_pc=0x100, next req addr 0x100.
//  5 Wrap: RESET_PC=0xFFFF_FFF8 -> req addrs 0xFFFF_FFF8,0xFFFF_FFFC,0x0.
//  6 Random mem latency 1-4 + random instr_ready + random redirects, scoreboard vs reference PC
//    model -> every delivered instr_pc/instr pair correct and in program order.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  // Canonical "addi x0, x0, 0", shown on the instr bus when nothing is valid.
  localparam word_t NOP = 32'h0000_0013;

  // One buffered fetch: {pc, instr}, 64 bits.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  // Word-align a byte address.
  function automatic word_t align_word(word_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch stage's memory, redirect and decoder-side channels.
interface instr_fetch_unit_if;

  logic                        imem_req_valid;
  instr_fetch_unit_pkg::word_t imem_req_addr;
  logic                        imem_req_ready;
  logic                        imem_rsp_valid;
  instr_fetch_unit_pkg::word_t imem_rsp_data;
  logic                        redirect_valid;
  instr_fetch_unit_pkg::word_t redirect_pc;
  logic                        instr_valid;
  instr_fetch_unit_pkg::word_t instr;
  instr_fetch_unit_pkg::word_t instr_pc;
  logic                        instr_ready;

  // The fetch unit itself.
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );

  // Memory, branch unit and decoder around it.
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two >= 2.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_en  = pop && !empty && !flush;
  assign push_en = push && (!full || pop_en) && !flush;

  // Pointers and occupancy; flush behaves like a local reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word reads, pairs in-order responses with
// their address tags, buffers {pc, instr} and presents them to the decoder. A redirect flushes
// the buffers and marks every in-flight response for discard.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter word_t       RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

  word_t         pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] kill_q, kill_d;

  logic          req_valid, req_fire, rsp_fire, rsp_keep;
  logic          instr_valid, instr_pop, buf_push;
  logic [CW:0]   inflight;

  word_t         tag_head;
  logic          tag_full, tag_empty;
  logic [CW-1:0] tag_count;

  fetch_entry_t  buf_head, buf_wdata;
  logic          buf_full, buf_empty;
  logic [CW-1:0] buf_count;

  // Killed requests still count as outstanding, so every kept response has a buffer slot.
  assign inflight    = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign req_valid   = !rst && !bus.redirect_valid && (inflight < CREDITS);
  assign req_fire    = req_valid && bus.imem_req_ready;
  assign rsp_fire    = bus.imem_rsp_valid && (outstanding_q != '0);
  assign rsp_keep    = rsp_fire && (kill_q == '0);
  assign buf_push    = rsp_keep && !bus.redirect_valid;
  assign instr_valid = !rst && !bus.redirect_valid && !buf_empty;
  assign instr_pop   = instr_valid && bus.instr_ready;

  assign buf_wdata.pc    = tag_head;
  assign buf_wdata.instr = bus.imem_rsp_data;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = instr_valid;
  assign bus.instr          = instr_valid ? buf_head.instr : NOP;
  assign bus.instr_pc       = buf_head.pc;

  // Address of every accepted request, popped by its (non-killed) response.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (req_fire),
    .wdata (pc_q),
    .pop   (rsp_keep),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Instruction buffer presented to the decoder.
  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (buf_push),
    .wdata (buf_wdata),
    .pop   (instr_pop),
    .rdata (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  // Next PC, outstanding-request and discard counters.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    kill_d        = kill_q;
    if (req_fire) pc_d = pc_q + word_t'(INSTR_BYTES);
    case ({req_fire, rsp_fire})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (rsp_fire && (kill_q != '0)) kill_d = kill_q - CW'(1);
    // Everything still in flight after this cycle belongs to the old path.
    if (bus.redirect_valid) begin
      pc_d   = align_word(bus.redirect_pc);
      kill_d = outstanding_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      kill_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
    end
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> (outstanding_q != '0));
  a_tag_tracks: assert property (@(posedge clk) disable iff (rst)
    tag_count == (outstanding_q - kill_q));
  a_tag_avail: assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> !tag_empty);
  a_tag_room: assert property (@(posedge clk) disable iff (rst)
    req_fire |-> (!tag_full || rsp_keep));
  a_buf_room: assert property (@(posedge clk) disable iff (rst)
    buf_push |-> (!buf_full || instr_pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit: an in-order memory with random latency, random decoder
// backpressure and random redirects, checked against a program-order PC model.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam word_t       MAGIC = 32'hA5A5_0000;

  typedef struct {
    word_t addr;
    int    due;
  } pend_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if wbus ();

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_fetch_unit #(
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (2)
  ) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus knobs.
  bit    rst_req;
  int    lat_min, lat_max, p_ready, p_mready, p_redir;
  bit    force_redir;
  word_t force_pc;

  // Memory and reference model.
  pend_t pend[$];
  int    cyc = 0;
  int    last_due = 0;
  word_t exp_req_pc, exp_pc;
  int    buffered, kill, reqs, delivered;
  word_t req_log[$];
  word_t del_log[$];

  // Wrap-instance bookkeeping.
  bit    w_rsp;
  word_t w_addr_prev;
  word_t w_log[$];

  int d0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, advance the model.
  task automatic step();
    bit    do_redir, rsp, fire, pop, exp_rv, w_fire;
    word_t rpc, raddr;
    int    out_now, lat, due;
    @(negedge clk);
    cyc++;
    rst = rst_req;
    if (rst) begin
      pend.delete();
      last_due = 0;
    end
    out_now = pend.size();
    rsp     = 1'b0;
    raddr   = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp   = 1'b1;
      raddr = pend[0].addr;
      void'(pend.pop_front());
    end
    do_redir = !rst && (force_redir || ($urandom_range(99) < p_redir));
    rpc      = force_redir ? force_pc : $urandom;

    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? (raddr ^ MAGIC) : $urandom;
    // Redirect is held high throughout reset: reset must win.
    bus.redirect_valid = rst ? 1'b1 : do_redir;
    bus.redirect_pc    = rst ? 32'h0000_0500 : rpc;
    bus.instr_ready    = ($urandom_range(99) < p_ready);
    bus.imem_req_ready = ($urandom_range(99) < p_mready);

    wbus.imem_req_ready = 1'b1;
    wbus.imem_rsp_valid = !rst && w_rsp;
    wbus.imem_rsp_data  = w_addr_prev ^ MAGIC;
    wbus.redirect_valid = 1'b0;
    wbus.redirect_pc    = '0;
    wbus.instr_ready    = 1'b1;
    #1;

    exp_rv = !rst && !do_redir && ((out_now + buffered) < DEPTH);
    check("req_valid", bus.imem_req_valid, exp_rv);
    if (bus.imem_req_valid) check("req_addr", bus.imem_req_addr, exp_req_pc);
    check("instr_valid", bus.instr_valid, !rst && !do_redir && (buffered > 0));
    fire = bus.imem_req_valid && bus.imem_req_ready;
    pop  = bus.instr_valid && bus.instr_ready;
    if (pop) begin
      check("instr_pc", bus.instr_pc, exp_pc);
      check("instr", bus.instr, exp_pc ^ MAGIC);
    end

    if (rst) begin
      exp_req_pc = '0;
      exp_pc     = '0;
      buffered   = 0;
      kill       = 0;
      reqs       = 0;
      req_log.delete();
      del_log.delete();
    end else if (do_redir) begin
      exp_req_pc = rpc & ~32'h3;
      exp_pc     = rpc & ~32'h3;
      buffered   = 0;
      kill       = pend.size();
      req_log.delete();
      del_log.delete();
    end else begin
      if (rsp) begin
        if (kill > 0) kill--;
        else buffered++;
      end
      if (pop) begin
        buffered--;
        delivered++;
        del_log.push_back(bus.instr_pc);
        exp_pc += 32'd4;
      end
      if (fire) begin
        exp_req_pc += 32'd4;
        reqs++;
        req_log.push_back(bus.imem_req_addr);
      end
    end
    if (fire) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: bus.imem_req_addr, due: due});
    end

    w_fire = !rst && wbus.imem_req_valid && wbus.imem_req_ready;
    if (rst) w_log.delete();
    else if (w_fire && w_log.size() < 3) w_log.push_back(wbus.imem_req_addr);
    w_rsp       = w_fire;
    w_addr_prev = wbus.imem_req_addr;
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.instr_ready     = 1'b0;
    wbus.imem_req_ready = 1'b0;
    wbus.imem_rsp_valid = 1'b0;
    wbus.imem_rsp_data  = '0;
    wbus.redirect_valid = 1'b0;
    wbus.redirect_pc    = '0;
    wbus.instr_ready    = 1'b0;
    w_rsp = 1'b0;
    w_addr_prev = '0;
    exp_req_pc = '0;
    exp_pc = '0;
    buffered = 0;
    kill = 0;
    reqs = 0;
    delivered = 0;
    force_redir = 1'b0;
    force_pc = '0;

    // Reset, then streaming from a zero-wait (1-cycle) memory.
    rst_req = 1'b1; lat_min = 1; lat_max = 1; p_ready = 100; p_mready = 100; p_redir = 0;
    repeat (3) step();
    rst_req = 1'b0;
    repeat (30) step();
    check("reset_req0", req_log[0], 32'h0);
    check("reset_req1", req_log[1], 32'h4);
    check("reset_req2", req_log[2], 32'h8);
    d0 = delivered;
    repeat (20) step();
    check("stream_rate", delivered - d0, 20);
    check("wrap_cnt", w_log.size(), 3);
    check("wrap_req0", w_log[0], 32'hFFFF_FFF8);
    check("wrap_req1", w_log[1], 32'hFFFF_FFFC);
    check("wrap_req2", w_log[2], 32'h0000_0000);

    // Decoder backpressure: credits cap requests at the buffer depth.
    rst_req = 1'b1;
    repeat (2) step();
    rst_req = 1'b0; p_ready = 0;
    repeat (10) step();
    check("bp_reqs", reqs, DEPTH);
    check("bp_head_valid", bus.instr_valid, 1'b1);
    check("bp_head_pc", bus.instr_pc, 32'h0);
    p_ready = 100;
    d0 = delivered;
    repeat (10) step();
    check("bp_release", (delivered - d0) >= 3, 1'b1);
    check("bp_del0", del_log[0], 32'h0);
    check("bp_del1", del_log[1], 32'h4);
    check("bp_del2", del_log[2], 32'h8);

    // Redirect with two requests in flight.
    rst_req = 1'b1;
    repeat (2) step();
    rst_req = 1'b0; lat_min = 3; lat_max = 3;
    repeat (2) step();
    force_redir = 1'b1; force_pc = 32'h0000_0103;
    step();
    force_redir = 1'b0;
    repeat (15) step();
    check("redir_req0", req_log[0], 32'h100);
    check("redir_del0", del_log[0], 32'h100);
    check("redir_del1", del_log[1], 32'h104);

    // Random latency, backpressure and redirects, then a burst of back-to-back redirects.
    lat_min = 1; lat_max = 4; p_ready = 70; p_mready = 70; p_redir = 3;
    d0 = delivered;
    repeat (3000) step();
    p_redir = 40;
    repeat (300) step();
    p_redir = 0; p_ready = 100; p_mready = 100;
    repeat (20) step();
    check("rand_progress", (delivered - d0) > 200, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
